// File: rtl/spi_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_mem_pkg
// Description : Shared definitions for the SPI memory host controller:
//               two-bit frame command codes, frame geometry and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_mem_pkg;

  // Frame command codes (first two payload bits of every frame)
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Frame geometry
  localparam int PAYLOAD_BITS = 10;
  localparam int DATA_BITS    = 8;

  // Controller states. The ST_ prefix keeps the names clear of the GAP
  // parameter of the top level.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_SEL    = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_SAMPLE = 3'd5,
    ST_GAP    = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_bit_shifter.sv
`default_nettype none
// ============================================================================
// Module      : spi_bit_shifter
// Description : 10-bit parallel-load, MSB-first shift register shared by the
//               transmit path (shift_out, zero fill) and the receive path
//               (shift_in of the serial input into the low bits).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_load/i_load_data - parallel load of a frame payload
//               i_shift_out        - shift left, zero into bit 0
//               i_shift_in         - shift left, i_ser_in into bit 0
//               i_ser_in           - serial input (MISO)
//               o_msb              - current MSB (next bit to transmit)
//               o_capture          - byte the register would hold after one
//                                    more shift_in (low 7 bits + i_ser_in)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bit_shifter
  import spi_mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic [PAYLOAD_BITS-1:0] i_load_data,
  input  logic                    i_shift_out,
  input  logic                    i_shift_in,
  input  logic                    i_ser_in,
  output logic                    o_msb,
  output logic [DATA_BITS-1:0]    o_capture
);

  logic [PAYLOAD_BITS-1:0] shreg_q;
  logic [PAYLOAD_BITS-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (i_load) begin
      shreg_d = i_load_data;
    end else if (i_shift_out) begin
      shreg_d = {shreg_q[PAYLOAD_BITS-2:0], 1'b0};
    end else if (i_shift_in) begin
      shreg_d = {shreg_q[PAYLOAD_BITS-2:0], i_ser_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign o_msb     = shreg_q[PAYLOAD_BITS-1];
  // Lets the final received bit land in the response register on the same
  // edge that completes the capture.
  assign o_capture = {shreg_q[DATA_BITS-2:0], i_ser_in};

endmodule
`default_nettype wire

// File: rtl/spi_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_mem_master
// Description : Host-side SPI controller for the 256x8 SPI memory block.
//               Each request becomes two SPI frames (address, then data),
//               one bit per clk. Reads capture 8 MISO bits after RD_WAIT
//               cycles. A one-cycle rsp_valid pulse marks completion.
// Ports       : clk, rst                      - clock, sync active-high reset
//               req_valid/req_ready           - request handshake
//               req_write/req_addr/req_wdata  - request fields
//               rsp_valid/rsp_rdata           - completion pulse, read byte
//               SS_n/MOSI/MISO                - SPI pins
// Revision    : 1.0 - initial release
// ============================================================================
module spi_mem_master
  import spi_mem_pkg::*;
#(
  parameter int RD_WAIT = 2,
  parameter int GAP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  // Down-counter reload values; each phase runs until the counter hits 0.
  localparam logic [3:0] SHIFT_INIT  = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0] WAIT_INIT   = 4'(RD_WAIT - 1);
  localparam logic [3:0] SAMPLE_INIT = 4'(DATA_BITS - 1);
  localparam logic [3:0] GAP_INIT    = 4'(GAP - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;        // 0 = first frame, 1 = second frame
  logic       write_q, write_d;
  logic [7:0] wdata_q, wdata_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;

  logic                    sh_load;
  logic [PAYLOAD_BITS-1:0] sh_load_data;
  logic                    sh_shift_out;
  logic                    sh_shift_in;
  logic                    sh_msb;
  logic [DATA_BITS-1:0]    sh_capture;

  spi_bit_shifter u_shifter (
    .clk         (clk),
    .rst         (rst),
    .i_load      (sh_load),
    .i_load_data (sh_load_data),
    .i_shift_out (sh_shift_out),
    .i_shift_in  (sh_shift_in),
    .i_ser_in    (MISO),
    .o_msb       (sh_msb),
    .o_capture   (sh_capture)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    sh_load      = 1'b0;
    sh_load_data = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d      = ST_LEAD;
          phase_d      = 1'b0;
          write_d      = req_write;
          wdata_d      = req_wdata;
          sh_load      = 1'b1;
          sh_load_data = {(req_write ? CMD_WR_ADDR : CMD_RD_ADDR), req_addr};
        end
      end
      ST_LEAD: begin
        state_d = ST_SEL;
      end
      ST_SEL: begin
        state_d = ST_SHIFT;
        cnt_d   = SHIFT_INIT;
      end
      ST_SHIFT: begin
        if (cnt_q == 4'd0) begin
          if (phase_q && !write_q) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GAP_INIT;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_SAMPLE;
          cnt_d   = SAMPLE_INIT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_INIT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 4'd0) begin
          if (phase_q) begin
            state_d = ST_IDLE;
            phase_d = 1'b0;
          end else begin
            state_d      = ST_LEAD;
            phase_d      = 1'b1;
            sh_load      = 1'b1;
            sh_load_data = write_q ? {CMD_WR_DATA, wdata_q}
                                   : {CMD_RD_DATA, 8'h00};
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin outputs are registered from the next state so they line up with
  // state_q. The shifter advances whenever the next cycle is a SHIFT cycle,
  // so its MSB is always the bit to present next.
  always_comb begin
    sh_shift_out = (state_d == ST_SHIFT);
    sh_shift_in  = (state_q == ST_SAMPLE);
    ss_n_d       = (state_d == ST_IDLE) || (state_d == ST_GAP);

    case (state_d)
      ST_SEL:   mosi_d = !write_q;
      ST_SHIFT: mosi_d = sh_msb;
      default:  mosi_d = 1'b0;
    endcase

    rsp_valid_d = phase_q && (state_q != ST_GAP) && (state_d == ST_GAP);
    rsp_rdata_d = (rsp_valid_d && !write_q) ? sh_capture : rsp_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      phase_q     <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= 8'h00;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_mem_master
// Description : Self-checking bench for spi_mem_master. A behavioural SPI
//               memory model answers on MISO (noise or X outside the read
//               window); each transaction is compared cycle by cycle against
//               an expected pin waveform built from the frame rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_mem_master;

  localparam int RD_WAIT = 2;
  localparam int GAP     = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_mem_master #(.RD_WAIT(RD_WAIT), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural SPI memory (slave side) ----------------
  logic [7:0] s_mem [256];
  int         sn;
  logic [9:0] spay;
  logic [7:0] saddr;
  logic [7:0] s_byte;
  bit         srd;
  bit         miso_x_mode = 1'b0;

  always @(negedge clk) begin
    if (SS_n !== 1'b0) begin
      sn  = 0;
      srd = 1'b0;
      if (miso_x_mode) MISO = 1'bx; else MISO = 1'($urandom_range(0, 1));
    end else begin
      if (sn >= 2 && sn <= 11) spay = {spay[8:0], MOSI};
      if (sn == 11) begin
        case (spay[9:8])
          2'b00:   saddr = spay[7:0];
          2'b01:   s_mem[saddr] = spay[7:0];
          2'b10:   saddr = spay[7:0];
          default: srd = 1'b1;
        endcase
      end
      if (srd && sn >= 12 + RD_WAIT && sn < 20 + RD_WAIT) begin
        s_byte = s_mem[saddr];
        MISO   = s_byte[7 - (sn - 12 - RD_WAIT)];
      end else if (miso_x_mode) begin
        MISO = 1'bx;
      end else begin
        MISO = 1'($urandom_range(0, 1));
      end
      sn++;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [256];
  logic [7:0] last_rdata;
  bit exp_ss[$];
  bit exp_mo[$];
  bit exp_care[$];

  task automatic push(input bit s, input bit m, input bit c);
    exp_ss.push_back(s);
    exp_mo.push_back(m);
    exp_care.push_back(c);
  endtask

  // One frame: lead, select bit, 10 payload bits, optional read window, gap.
  task automatic add_frame(input logic [1:0] cmd, input logic [7:0] pl, input bit sel, input bit rd);
    logic [9:0] f;
    f = {cmd, pl};
    push(1'b0, 1'b0, 1'b1);
    push(1'b0, sel, 1'b1);
    for (int i = 9; i >= 0; i--) push(1'b0, f[i], 1'b1);
    if (rd) begin
      for (int i = 0; i < RD_WAIT; i++) push(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) push(1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < GAP; i++) push(1'b1, 1'b0, 1'b1);
  endtask

  // Starts at a negedge, ends at the negedge of the first IDLE cycle.
  task automatic run_txn(input bit w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input bit hold);
    int waited;
    int rsp_idx;
    int bad_wave;
    int bad_rsp;
    int busy;
    logic [7:0] got_rd;
    exp_ss.delete();
    exp_mo.delete();
    exp_care.delete();
    add_frame(w ? 2'b00 : 2'b10, a, !w, 1'b0);
    add_frame(w ? 2'b01 : 2'b11, w ? d : 8'h00, !w, !w);
    rsp_idx = 24 + GAP + (w ? 0 : RD_WAIT + 8);

    waited = 0;
    while (req_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;

    bad_wave = -1;
    bad_rsp  = -1;
    busy     = 0;
    got_rd   = 8'h00;
    for (int i = 0; i < exp_ss.size(); i++) begin
      @(negedge clk);
      if (hold) begin
        req_write = 1'($urandom_range(0, 1));
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      if (bad_wave < 0 && (SS_n !== exp_ss[i] || (exp_care[i] && MOSI !== exp_mo[i])))
        bad_wave = i;
      if (bad_rsp < 0 && rsp_valid !== (i == rsp_idx)) bad_rsp = i;
      if (req_ready !== 1'b0) busy++;
      if (i == rsp_idx) got_rd = rsp_rdata;
    end
    @(negedge clk);
    check("pin_wave_first_bad_cycle", bad_wave, -1);
    check("rsp_valid_first_bad_cycle", bad_rsp, -1);
    check(w ? "rsp_rdata_held_on_write" : "rsp_rdata_read", 32'(got_rd), 32'(exp_rd));
    check("ready_high_while_busy_cycles", busy, 0);
    check("ready_after_txn", 32'(req_ready), 32'd1);
    if (w) ref_mem[a] = d;
    else   last_rdata = exp_rd;
  endtask

  typedef struct {
    bit         write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int quiet;
    bit w;
    logic [7:0] a;
    logic [7:0] d;

    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 8'h10, 8'h5A, 8'h00};
    vecs[2] = '{1'b0, 8'h10, 8'h00, 8'h5A};
    vecs[3] = '{1'b0, 8'h3C, 8'h00, 8'hA5};
    vecs[4] = '{1'b0, 8'h77, 8'h00, 8'h2D};   // untouched: 8'h77 ^ 8'h5A
    vecs[5] = '{1'b1, 8'h77, 8'hC3, 8'h00};
    vecs[6] = '{1'b0, 8'h77, 8'h00, 8'hC3};

    for (int i = 0; i < 256; i++) begin
      s_mem[i]   = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    last_rdata = 8'h00;

    // Reset state, with a request offered during reset
    rst       = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ss_n", 32'(SS_n), 32'd1);
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst       = 1'b0;
    req_valid = 1'b0;
    #1;
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // Table-driven back-to-back transactions
    for (int i = 0; i < 7; i++)
      run_txn(vecs[i].write, vecs[i].addr, vecs[i].wdata,
              vecs[i].write ? last_rdata : vecs[i].exp_rdata, 1'b0);

    // req_valid held through a write with changing fields, then a read
    run_txn(1'b1, 8'h20, 8'h11, last_rdata, 1'b1);
    run_txn(1'b0, 8'h20, 8'h00, 8'h11, 1'b0);

    // X on MISO outside the read window
    miso_x_mode = 1'b1;
    run_txn(1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0);
    check("rsp_rdata_has_x", 32'($isunknown(rsp_rdata)), 32'd0);
    miso_x_mode = 1'b0;

    // Reset during SHIFT of the first frame, request offered alongside rst
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h3C;
    req_wdata = 8'h11;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_ss_low", 32'(SS_n), 32'd0);
    rst       = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_ss_n", 32'(SS_n), 32'd1);
    check("mid_rst_mosi", 32'(MOSI), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    @(negedge clk);
    check("rst_beats_req_ss_n", 32'(SS_n), 32'd1);
    rst       = 1'b0;
    req_valid = 1'b0;
    last_rdata = 8'h00;
    #1;
    check("ready_after_mid_rst", 32'(req_ready), 32'd1);
    quiet = 0;
    repeat (30) begin
      @(negedge clk);
      if (SS_n !== 1'b1 || rsp_valid !== 1'b0) quiet++;
    end
    check("activity_after_abort_cycles", quiet, 0);
    run_txn(1'b1, 8'h00, 8'hFF, last_rdata, 1'b0);
    run_txn(1'b0, 8'h00, 8'h00, 8'hFF, 1'b0);

    // Randomized traffic against the reference memory
    for (int k = 0; k < 40; k++) begin
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      run_txn(w, a, d, w ? last_rdata : ref_mem[a], ($urandom_range(0, 4) == 0));
    end
    req_valid = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
